// File: rtl/stack_port_ctrl_if.sv
// Request/response channel between a stack client (master) and stack_port_ctrl (slave).
// One request is in flight at a time; done pulses for one cycle with pop_data/err valid.
interface stack_port_ctrl_if;
    logic        op_valid;
    logic        op_pop;
    logic [15:0] push_data;
    logic        op_ready;
    logic        done;
    logic [15:0] pop_data;
    logic        err;

    modport master (
        output op_valid,
        output op_pop,
        output push_data,
        input  op_ready,
        input  done,
        input  pop_data,
        input  err
    );

    modport slave (
        input  op_valid,
        input  op_pop,
        input  push_data,
        output op_ready,
        output done,
        output pop_data,
        output err
    );
endinterface

// File: rtl/stack_port_ctrl.sv
// Push/pop sequencer: reads SP from register-file address 1, moves one word to or from memory,
// writes SP back. Optional bounds checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module stack_port_ctrl #(
    parameter logic [15:0] SP_STEP     = 16'd2,
    parameter logic [15:0] STACK_TOP   = 16'h7FCD,
    parameter logic [15:0] STACK_LIMIT = 16'h4000
) (
    input  logic             clk,
    input  logic             reset,
    stack_port_ctrl_if.slave op,
    output logic [1:0]       rf_address,
    output logic [15:0]      rf_w_data,
    output logic             rf_regWrite,
    input  logic [15:0]      rf_r_data,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_w_data,
    output logic             mem_write,
    input  logic [15:0]      mem_r_data
);

    localparam logic [1:0] RF_SP  = 2'd1;
    localparam logic [1:0] RF_NOP = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SP_REQ,
        SP_CAP,
        MEM_WR,
        MEM_RD,
        MEM_CAP,
        SP_WR,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        is_pop_q, is_pop_d;
    logic [15:0] data_q, data_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] pop_data_q, pop_data_d;
    logic [15:0] sp_dec, sp_inc;
    logic        bound_fail;
    logic        op_ready_c, done_c;

    // Wrap-around at 16 bits is intended; the stack pointer is a plain modulo-2^16 address.
    assign sp_dec = sp_q - SP_STEP;
    assign sp_inc = sp_q + SP_STEP;

`ifdef STACK_BOUNDS_CHECK_EN
    logic [15:0] cap_dec, cap_inc;
    logic        err_q, err_d;

    // Checked against the SP value arriving this cycle, before it lands in sp_q.
    assign cap_dec    = rf_r_data - SP_STEP;
    assign cap_inc    = rf_r_data + SP_STEP;
    assign bound_fail = is_pop_q ? (cap_inc > STACK_TOP) : (cap_dec < STACK_LIMIT);

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && op.op_valid) begin
            err_d = 1'b0;
        end else if (state_q == SP_CAP) begin
            err_d = bound_fail;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign op.err = err_q;
`else
    assign bound_fail = 1'b0;
    assign op.err     = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        is_pop_d    = is_pop_q;
        data_d      = data_q;
        sp_d        = sp_q;
        pop_data_d  = pop_data_q;
        op_ready_c  = 1'b0;
        done_c      = 1'b0;
        rf_address  = RF_NOP;
        rf_w_data   = 16'h0000;
        rf_regWrite = 1'b0;
        mem_addr    = 16'h0000;
        mem_w_data  = 16'h0000;
        mem_write   = 1'b0;

        case (state_q)
            IDLE: begin
                op_ready_c = 1'b1;
                if (op.op_valid) begin
                    is_pop_d = op.op_pop;
                    data_d   = op.push_data;
                    state_d  = SP_REQ;
                end
            end
            SP_REQ: begin
                rf_address = RF_SP;
                state_d    = SP_CAP;
            end
            SP_CAP: begin
                sp_d = rf_r_data;
                if (bound_fail) begin
                    state_d = DONE;
                end else if (is_pop_q) begin
                    state_d = MEM_RD;
                end else begin
                    state_d = MEM_WR;
                end
            end
            MEM_WR: begin
                mem_addr   = sp_dec;
                mem_w_data = data_q;
                mem_write  = 1'b1;
                state_d    = SP_WR;
            end
            MEM_RD: begin
                mem_addr = sp_q;
                state_d  = MEM_CAP;
            end
            MEM_CAP: begin
                pop_data_d = mem_r_data;
                state_d    = SP_WR;
            end
            SP_WR: begin
                rf_address  = RF_SP;
                rf_regWrite = 1'b1;
                rf_w_data   = is_pop_q ? sp_inc : sp_dec;
                state_d     = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            is_pop_q   <= 1'b0;
            data_q     <= 16'h0000;
            sp_q       <= 16'h0000;
            pop_data_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            is_pop_q   <= is_pop_d;
            data_q     <= data_d;
            sp_q       <= sp_d;
            pop_data_q <= pop_data_d;
        end
    end

    assign op.op_ready = op_ready_c;
    assign op.done     = done_c;
    assign op.pop_data = pop_data_q;

endmodule
